// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-stage registers between D/E, E/M and M/W.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package pipe_pkg;

    // Exception code meaning "no exception".
    localparam int EXC_NONE = 0;

    // PC presented on out_pc after reset (boot vector of the core).
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    // Occupancy of a stage: nothing, head only, head plus skid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    // Payload field layout used by the stages to pack and unpack DATA_W.
    localparam int PL_FIELD_W   = 32;
    localparam int PL_INSTR_LSB = 0;
    localparam int PL_ALU_LSB   = 32;
    localparam int PL_RT_LSB    = 64;
    localparam int PL_HILO_LSB  = 96;

endpackage

// File: rtl/pipe_entry.sv
// One stage entry: valid bit plus pc, payload, exception code and delay-slot flag.
// Latency: load/clear/flush take effect at the next clock edge.
// Backpressure: none; the owner decides when to load or clear.
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int               DATA_W   = 128,
    parameter int               PC_W     = 32,
    parameter int               EXC_W    = 5,
    parameter logic [PC_W-1:0]  RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic              flush,
    input  logic [PC_W-1:0]   flush_pc,
    input  logic [PC_W-1:0]   ld_pc,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [EXC_W-1:0]  ld_exc,
    input  logic              ld_bd,
    output logic              vld,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] data,
    output logic [EXC_W-1:0]  exc,
    output logic              bd
);

    logic              vld_q, vld_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [EXC_W-1:0]  exc_q, exc_d;
    logic              bd_q, bd_d;

    // Flush plants a bubble carrying flush_pc; otherwise load beats clear.
    always_comb begin
        vld_d  = vld_q;
        pc_d   = pc_q;
        data_d = data_q;
        exc_d  = exc_q;
        bd_d   = bd_q;
        if (flush) begin
            vld_d  = 1'b0;
            pc_d   = flush_pc;
            data_d = '0;
            exc_d  = '0;
            bd_d   = 1'b0;
        end else if (load) begin
            vld_d  = 1'b1;
            pc_d   = ld_pc;
            data_d = ld_data;
            exc_d  = ld_exc;
            bd_d   = ld_bd;
        end else if (clear) begin
            vld_d  = 1'b0;
        end
    end

    // Entry storage; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= 1'b0;
            pc_q   <= RESET_PC;
            data_q <= '0;
            exc_q  <= '0;
            bd_q   <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            pc_q   <= pc_d;
            data_q <= data_d;
            exc_q  <= exc_d;
            bd_q   <= bd_d;
        end
    end

    assign vld  = vld_q;
    assign pc   = pc_q;
    assign data = data_q;
    assign exc  = exc_q;
    assign bd   = bd_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready pipeline stage with optional skid entry, flush bubble and stall counter.
// Latency: one cycle from accept to out_*; one entry per cycle while out_ready is high.
// Backpressure: SKID=1 gives a registered in_ready (drops only when full); SKID=0 passes out_ready through.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int               DATA_W   = 128,
    parameter int               PC_W     = 32,
    parameter logic [PC_W-1:0]  RESET_PC = PC_W'(RESET_PC_DEFAULT),
    parameter int               EXC_W    = 5,
    parameter int               SKID     = 1,
    parameter int               CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic              in_bd,
    input  logic [EXC_W-1:0]  local_exc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [EXC_W-1:0]  out_exc,
    output logic              out_bd,
    input  logic              flush,
    input  logic [PC_W-1:0]   flush_pc,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_e            state_q, state_d;
    logic              in_rdy_q, in_rdy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              accept, issue;
    logic [EXC_W-1:0]  cap_exc;
    logic              head_load, head_clr, head_from_skid;
    logic              skid_load, skid_clr;

    logic              head_vld;
    logic [PC_W-1:0]   hd_pc;
    logic [DATA_W-1:0] hd_data;
    logic [EXC_W-1:0]  hd_exc;
    logic              hd_bd;

    logic              skid_vld;
    logic [PC_W-1:0]   skid_pc;
    logic [DATA_W-1:0] skid_data;
    logic [EXC_W-1:0]  skid_exc;
    logic              skid_bd;

    assign accept = in_valid & in_ready;
    assign issue  = head_vld & out_ready;

    // The earliest exception wins: an upstream code masks the local one.
    assign cap_exc = (in_exc != EXC_W'(EXC_NONE)) ? in_exc : local_exc;

    // Head refills from the skid when draining FULL, otherwise from the input.
    assign hd_pc   = head_from_skid ? skid_pc   : in_pc;
    assign hd_data = head_from_skid ? skid_data : in_data;
    assign hd_exc  = head_from_skid ? skid_exc  : cap_exc;
    assign hd_bd   = head_from_skid ? skid_bd   : in_bd;

    // Occupancy FSM: decides which entry loads or clears; flush empties the stage.
    always_comb begin
        state_d        = state_q;
        head_load      = 1'b0;
        head_clr       = 1'b0;
        head_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        head_load = 1'b1;
                        state_d   = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && issue) begin
                        head_load = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                        state_d   = ST_FULL;
                    end else if (issue) begin
                        head_clr  = 1'b1;
                        state_d   = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (issue && skid_vld) begin
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                        state_d        = ST_ONE;
                    end else if (issue) begin
                        head_clr = 1'b1;
                        state_d  = ST_EMPTY;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        in_rdy_d = (state_d != ST_FULL);
    end

    // Saturating count of cycles where the head waits on downstream.
    always_comb begin
        cnt_d = cnt_q;
        if (head_vld && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Control state; in_ready comes straight from a flop for the skid variant.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_EMPTY;
            in_rdy_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            in_rdy_q <= in_rdy_d;
            cnt_q    <= cnt_d;
        end
    end

    pipe_entry #(
        .DATA_W   (DATA_W),
        .PC_W     (PC_W),
        .EXC_W    (EXC_W),
        .RESET_PC (RESET_PC)
    ) u_head (
        .clk      (clk),
        .reset    (reset),
        .load     (head_load),
        .clear    (head_clr),
        .flush    (flush),
        .flush_pc (flush_pc),
        .ld_pc    (hd_pc),
        .ld_data  (hd_data),
        .ld_exc   (hd_exc),
        .ld_bd    (hd_bd),
        .vld      (head_vld),
        .pc       (out_pc),
        .data     (out_data),
        .exc      (out_exc),
        .bd       (out_bd)
    );

    if (SKID != 0) begin : g_skid
        pipe_entry #(
            .DATA_W   (DATA_W),
            .PC_W     (PC_W),
            .EXC_W    (EXC_W),
            .RESET_PC (RESET_PC)
        ) u_skid (
            .clk      (clk),
            .reset    (reset),
            .load     (skid_load),
            .clear    (skid_clr),
            .flush    (flush),
            .flush_pc (flush_pc),
            .ld_pc    (in_pc),
            .ld_data  (in_data),
            .ld_exc   (cap_exc),
            .ld_bd    (in_bd),
            .vld      (skid_vld),
            .pc       (skid_pc),
            .data     (skid_data),
            .exc      (skid_exc),
            .bd       (skid_bd)
        );
        assign in_ready = in_rdy_q;
    end else begin : g_noskid
        assign skid_vld  = 1'b0;
        assign skid_pc   = '0;
        assign skid_data = '0;
        assign skid_exc  = '0;
        assign skid_bd   = 1'b0;
        assign in_ready  = out_ready | ~head_vld;
    end

    assign out_valid = head_vld;
    assign stall_cnt = cnt_q;

endmodule
